game_end_of_game_timer: RTL and testbench

// Countdown timer for one game, next to the game master FSM. It consumes the
// FSM's one-cycle end_of_game_timer_start pulse and produces the
// end_of_game_timer_running level that the FSM samples. It also drives the

---
 rtl/game_end_of_game_timer.sv | 192 +++++++++++++++++++
 tb/tb_game_end_of_game_timer.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/game_end_of_game_timer.sv
// game_end_of_game_timer: end-of-game countdown beside the game master FSM.
// A start pulse loads DURATION_SEC and counts down once per CLK_HZ cycles.
// It reports running/expired to the FSM, and the remaining seconds in binary
// and BCD to the display.
// Optional feature: define GAME_TIMER_WARNING_EN to build the 2 Hz warning
// blink for the last WARN_SEC seconds. Without it, warning is always 0.
module game_end_of_game_timer #(
    parameter int CLK_HZ       = 50_000_000,
    parameter int DURATION_SEC = 30,
    parameter int WARN_SEC     = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       pause,
    output logic       running,
    output logic       expired,
    output logic [6:0] seconds_left,
    output logic [3:0] bcd_tens,
    output logic [3:0] bcd_ones,
    output logic       warning
);

    localparam int            PW         = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PRE_LAST   = PW'(CLK_HZ - 1);
    localparam logic [6:0]    DUR        = 7'(DURATION_SEC);
    localparam logic [3:0]    DUR_TENS   = 4'(DURATION_SEC / 10);
    localparam logic [3:0]    DUR_ONES   = 4'(DURATION_SEC % 10);
    localparam logic [6:0]    WARN_LIMIT = 7'(WARN_SEC);
    localparam bit            ZERO_DUR   = (DURATION_SEC == 0);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        EXPIRE
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [PW-1:0] prescaler;
    logic [PW-1:0] prescaler_next;
    logic [6:0]    seconds_next;
    logic [3:0]    tens_next;
    logic [3:0]    ones_next;
    logic          running_next;
    logic          expired_next;
    logic          warning_next;
    logic          blink_next;
    logic          tick;
    logic          last_tick;

    // One-second tick: only while counting and not paused.
    assign tick      = (state == RUN) && !pause && (prescaler == PRE_LAST);
    // The tick that takes the count to zero. The <= also covers a stray 0 while in RUN.
    assign last_tick = tick && (seconds_left <= 7'd1);

    // State register plus registered outputs. Reset aborts without an expired pulse.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            prescaler    <= '0;
            seconds_left <= '0;
            bcd_tens     <= '0;
            bcd_ones     <= '0;
            running      <= 1'b0;
            expired      <= 1'b0;
            warning      <= 1'b0;
        end else begin
            state        <= state_next;
            prescaler    <= prescaler_next;
            seconds_left <= seconds_next;
            bcd_tens     <= tens_next;
            bcd_ones     <= ones_next;
            running      <= running_next;
            expired      <= expired_next;
            warning      <= warning_next;
        end
    end

    // Next state. start beats any tick or expiry on the same edge.
    always_comb begin
        state_next = state;
        if (start) begin
            state_next = ZERO_DUR ? EXPIRE : RUN;
        end else begin
            case (state)
                IDLE:    state_next = IDLE;
                RUN:     if (last_tick) state_next = EXPIRE;
                EXPIRE:  state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Next values of the prescaler and the registered outputs.
    // Everything holds unless a start, a count step or the end of the count changes it.
    always_comb begin
        prescaler_next = prescaler;
        seconds_next   = seconds_left;
        tens_next      = bcd_tens;
        ones_next      = bcd_ones;
        running_next   = running;
        expired_next   = 1'b0;
        if (start) begin
            prescaler_next = '0;
            seconds_next   = DUR;
            tens_next      = DUR_TENS;
            ones_next      = DUR_ONES;
            running_next   = !ZERO_DUR;
            expired_next   = ZERO_DUR;
        end else begin
            case (state)
                RUN: begin
                    if (!pause) begin
                        if (tick) begin
                            prescaler_next = '0;
                            if (last_tick) begin
                                seconds_next = '0;
                                tens_next    = '0;
                                ones_next    = '0;
                                running_next = 1'b0;
                                expired_next = 1'b1;
                            end else begin
                                seconds_next = seconds_left - 7'd1;
                                // BCD decrements alongside the binary count, so no divider is needed
                                if (bcd_ones == 4'd0) begin
                                    ones_next = 4'd9;
                                    tens_next = bcd_tens - 4'd1;
                                end else begin
                                    ones_next = bcd_ones - 4'd1;
                                end
                            end
                        end else begin
                            prescaler_next = prescaler + 1'b1;
                        end
                    end
                end
                EXPIRE: begin
                    running_next = 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

`ifdef GAME_TIMER_WARNING_EN
    localparam int            QCYC   = (CLK_HZ / 4 > 0) ? CLK_HZ / 4 : 1;
    localparam int            BW     = (QCYC > 1) ? $clog2(QCYC) : 1;
    localparam logic [BW-1:0] Q_LAST = BW'(QCYC - 1);

    logic [BW-1:0] blink_cnt;
    logic [BW-1:0] blink_cnt_next;
    logic          blink;

    // Blink divider: cleared on start, advances only while counting unpaused.
    always_comb begin
        blink_cnt_next = blink_cnt;
        blink_next     = blink;
        if (start) begin
            blink_cnt_next = '0;
            blink_next     = 1'b0;
        end else if (state == RUN && !pause) begin
            if (blink_cnt == Q_LAST) begin
                blink_cnt_next = '0;
                blink_next     = !blink;
            end else begin
                blink_cnt_next = blink_cnt + 1'b1;
            end
        end
    end

    // Blink divider registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            blink_cnt <= '0;
            blink     <= 1'b0;
        end else begin
            blink_cnt <= blink_cnt_next;
            blink     <= blink_next;
        end
    end
`else
    assign blink_next = 1'b0;
`endif

    // Warning is computed from next values so it lines up with the digits it qualifies.
    always_comb begin
        warning_next = running_next && (seconds_next <= WARN_LIMIT) && blink_next;
    end

endmodule

// File: tb/tb_game_end_of_game_timer.sv
// Directed bench for game_end_of_game_timer (default build: warning disabled).
module tb_game_end_of_game_timer;

    logic       clk;
    logic       rst;
    logic       pause;
    logic       start3, start12, start0;

    logic       running3, expired3, warning3;
    logic [6:0] sec3;
    logic [3:0] tens3, ones3;
    logic       running12, expired12, warning12;
    logic [6:0] sec12;
    logic [3:0] tens12, ones12;
    logic       running0, expired0, warning0;
    logic [6:0] sec0;
    logic [3:0] tens0, ones0;

    int total = 0;
    int bad   = 0;
    int exp3_cnt = 0;
    int exp0_cnt = 0;
    int warn_seen = 0;
    int run0_seen = 0;

    game_end_of_game_timer #(.CLK_HZ(10), .DURATION_SEC(3), .WARN_SEC(2)) dut (
        .clk(clk), .rst(rst), .start(start3), .pause(pause),
        .running(running3), .expired(expired3), .seconds_left(sec3),
        .bcd_tens(tens3), .bcd_ones(ones3), .warning(warning3)
    );

    game_end_of_game_timer #(.CLK_HZ(10), .DURATION_SEC(12), .WARN_SEC(2)) dut12 (
        .clk(clk), .rst(rst), .start(start12), .pause(pause),
        .running(running12), .expired(expired12), .seconds_left(sec12),
        .bcd_tens(tens12), .bcd_ones(ones12), .warning(warning12)
    );

    game_end_of_game_timer #(.CLK_HZ(10), .DURATION_SEC(0), .WARN_SEC(2)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .pause(pause),
        .running(running0), .expired(expired0), .seconds_left(sec0),
        .bcd_tens(tens0), .bcd_ones(ones0), .warning(warning0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse and level monitors, sampled mid-cycle
    always @(negedge clk) begin
        if (expired3) exp3_cnt++;
        if (expired0) exp0_cnt++;
        if (warning3 || warning12 || warning0) warn_seen++;
        if (running0) run0_seen++;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b0; pause = 1'b0; start3 = 1'b0; start12 = 1'b0; start0 = 1'b0;
        step(2);
        chk("rst_running", running3, 0);
        chk("rst_expired", expired3, 0);
        chk("rst_seconds", sec3, 0);
        chk("rst_tens", tens3, 0);
        chk("rst_ones", ones3, 0);
        chk("rst_warning", warning3, 0);
        rst = 1'b1;
        step(1);

        // Basic countdown: 3 -> 2 -> 1 -> 0 at 10-cycle spacing
        start3 = 1'b1; step(1); start3 = 1'b0;
        chk("load_running", running3, 1);
        chk("load_seconds", sec3, 3);
        chk("load_tens", tens3, 0);
        chk("load_ones", ones3, 3);
        step(9);
        chk("pre_tick_seconds", sec3, 3);
        step(1);
        chk("tick1_seconds", sec3, 2);
        chk("tick1_ones", ones3, 2);
        step(10);
        chk("tick2_seconds", sec3, 1);
        step(9);
        chk("pre_exp_expired", expired3, 0);
        chk("pre_exp_running", running3, 1);
        step(1);
        chk("exp_expired", expired3, 1);
        chk("exp_running", running3, 0);
        chk("exp_seconds", sec3, 0);
        chk("exp_ones", ones3, 0);
        step(1);
        chk("post_exp_expired", expired3, 0);
        chk("post_exp_running", running3, 0);
        chk("post_exp_seconds", sec3, 0);

        // Pause 25 cycles mid-second: everything shifts by 25
        start3 = 1'b1; step(1); start3 = 1'b0;
        step(5);
        pause = 1'b1;
        step(25);
        chk("pause_seconds", sec3, 3);
        chk("pause_running", running3, 1);
        pause = 1'b0;
        step(4);
        chk("pause_pre_tick", sec3, 3);
        step(1);
        chk("pause_tick1", sec3, 2);
        step(9);
        chk("pause_sec2_hold", sec3, 2);
        step(1);
        chk("pause_tick2", sec3, 1);
        step(9);
        chk("pause_pre_exp", expired3, 0);
        step(1);
        chk("pause_exp", expired3, 1);
        chk("pause_exp_running", running3, 0);
        step(1);

        // Restart on the final tick: start wins, no expiry
        start3 = 1'b1; step(1); start3 = 1'b0;
        step(29);
        chk("final_pre_seconds", sec3, 1);
        start3 = 1'b1; step(1); start3 = 1'b0;
        chk("restart_seconds", sec3, 3);
        chk("restart_running", running3, 1);
        chk("restart_expired", expired3, 0);
        step(1);
        chk("restart_expired_next", expired3, 0);
        chk("restart_running_next", running3, 1);
        step(28);
        chk("restart_sec1", sec3, 1);
        step(1);
        chk("restart_exp", expired3, 1);
        step(1);

        // Reset mid-run aborts silently
        start3 = 1'b1; step(1); start3 = 1'b0;
        step(12);
        chk("run_before_rst", sec3, 2);
        rst = 1'b0; step(1);
        chk("abort_running", running3, 0);
        chk("abort_seconds", sec3, 0);
        chk("abort_tens", tens3, 0);
        chk("abort_ones", ones3, 0);
        chk("abort_expired", expired3, 0);
        rst = 1'b1;
        step(35);
        chk("abort_idle_seconds", sec3, 0);
        chk("expired_pulse_count", exp3_cnt, 3);

        // Two-digit duration: ones wraps 0 -> 9 as tens drops
        start12 = 1'b1; step(1); start12 = 1'b0;
        chk("d12_load_sec", sec12, 12);
        chk("d12_load_bcd", {tens12, ones12}, 8'h12);
        step(10);
        chk("d12_11", {1'b0, sec12, tens12, ones12}, {1'b0, 7'd11, 8'h11});
        step(10);
        chk("d12_10", {1'b0, sec12, tens12, ones12}, {1'b0, 7'd10, 8'h10});
        step(10);
        chk("d12_09", {1'b0, sec12, tens12, ones12}, {1'b0, 7'd9, 8'h09});

        // Zero duration: immediate expiry, never running
        start0 = 1'b1; step(1); start0 = 1'b0;
        chk("d0_expired", expired0, 1);
        chk("d0_running", running0, 0);
        chk("d0_seconds", sec0, 0);
        step(1);
        chk("d0_expired_next", expired0, 0);
        step(2);
        chk("d0_pulse_count", exp0_cnt, 1);
        chk("d0_running_seen", run0_seen, 0);
        chk("warning_seen", warn_seen, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
